// File: rtl/dff_arbiter.sv
// dff_arbiter: round-robin arbiter and write sequencer for the shared WIDTH-bit register.
// Optional locked bursts are enabled with the DFF_ARB_LOCK_EN macro.
module dff_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
`ifdef DFF_ARB_LOCK_EN
    input  logic [N_REQ-1:0]         req_lock,
`endif
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [$clog2(N_REQ)-1:0] q_owner,
    output logic                     busy
);
    localparam int IW = $clog2(N_REQ);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, win_q, win_d, owner_q, owner_d, sel, idx;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d, win_req, hold;
    assign win_req = req[win_q];
`ifdef DFF_ARB_LOCK_EN
    localparam int LW = $clog2(MAX_LOCK) + 1;
    logic [LW-1:0] lock_q, lock_d;
    assign hold   = win_req & req_lock[win_q] & (lock_q < LW'(MAX_LOCK - 1));
    assign lock_d = (state_q == GRANT) ? (hold ? lock_q + 1'b1 : '0) : lock_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lock_q <= '0;
        else      lock_q <= lock_d;
    end
`else
    assign hold = 1'b0;
`endif
    // Descending scan so the requester closest to ptr (lowest offset) wins.
    always_comb begin
        sel = ptr_q;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr_q) + i) % N_REQ);
            if (req[idx]) sel = idx;
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        owner_d = owner_q;
        valid_d = 1'b0;
        if (state_q == IDLE) begin
            gnt_d = '0;
            if (|req) begin
                win_d   = sel;
                gnt_d   = N_REQ'(1) << sel;
                state_d = GRANT;
            end
        end else begin
            if (win_req) begin
                data_d  = req_data[win_q*WIDTH +: WIDTH];
                owner_d = win_q;
                valid_d = 1'b1;
            end
            if (!hold) begin
                ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                gnt_d   = '0;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
        end
    end
    assign gnt     = gnt_q;
    assign q       = data_q;
    assign q_valid = valid_q;
    assign q_owner = owner_q;
    assign busy    = (state_q == GRANT);
endmodule

// File: tb/tb_dff_arbiter.sv
// tb_dff_arbiter: directed and random checks of dff_arbiter against a transaction-level model.
module tb_dff_arbiter;
    localparam int N = 4, W = 4, ML = 4;
`ifdef DFF_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0;
    logic [N-1:0] req = '0, req_lock = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] gnt;
    logic [W-1:0] q;
    logic q_valid, busy;
    logic [1:0] q_owner;
    int vectors = 0, errors = 0;
    bit m_busy, m_valid;
    int m_w, m_ptr, m_owner, m_cnt;
    logic [W-1:0] m_q;

    dff_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
`ifdef DFF_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .gnt(gnt), .q(q), .q_valid(q_valid), .q_owner(q_owner), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int first_from(int p, logic [N-1:0] r);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_valid = 0; m_w = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_q = '0;
    endtask

    // One clock edge of the arbitration rules, applied to the current inputs.
    task automatic model_edge();
        bit locked;
        if (!m_busy) begin
            m_valid = 0;
            if (req != '0) begin
                m_w = first_from(m_ptr, req);
                m_busy = 1;
            end
        end else begin
            locked = LOCK && req[m_w] && req_lock[m_w] && (m_cnt < ML - 1);
            m_valid = req[m_w];
            if (req[m_w]) begin
                m_q = req_data[m_w*W +: W];
                m_owner = m_w;
            end
            if (locked) m_cnt++;
            else begin
                m_cnt = 0;
                m_ptr = (m_w + 1) % N;
                m_busy = 0;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_gnt"}, 32'(gnt), m_busy ? 32'(1) << m_w : 32'(0));
        chk({tag, "_q"}, 32'(q), 32'(m_q));
        chk({tag, "_valid"}, 32'(q_valid), 32'(m_valid));
        chk({tag, "_owner"}, 32'(q_owner), 32'(m_owner));
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
    endtask

    task automatic step(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();
        req = 4'b0100; req_data[8 +: 4] = 4'hA;
        step("single_gnt");
        chk("single_gnt_dir", 32'(gnt), 32'h4);
        step("single_commit");
        chk("single_q_dir", 32'(q), 32'hA);
        chk("single_owner_dir", 32'(q_owner), 32'd2);
        chk("single_valid_dir", 32'(q_valid), 32'd1);
        req = '0;
        step("single_hold");
        chk("single_hold_q", 32'(q), 32'hA);
        chk("single_hold_valid", 32'(q_valid), 32'd0);
        step("single_idle");
        do_reset();
        req = 4'b1111; req_data = 16'h3210;
        for (int i = 0; i < 8; i++) begin
            step("fair");
            if (i % 2 == 1) begin
                chk("fair_owner", 32'(q_owner), 32'(i / 2));
                chk("fair_q", 32'(q), 32'(i / 2));
            end
        end
        req = 4'b1001;
        step("wrap_gnt");
        chk("wrap_gnt_dir", 32'(gnt), 32'h1);
        step("wrap_commit");
        req = 4'b0010;
        step("abort_gnt");
        req = '0;
        step("abort");
        chk("abort_valid", 32'(q_valid), 32'd0);
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_owner", 32'(q_owner), 32'd0);
        req = 4'b0110;
        step("after_abort");
        chk("after_abort_gnt", 32'(gnt), 32'h4);
        step("after_abort_commit");
        req = 4'b0010;
        step("pre_async");
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        chk("async_q", 32'(q), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        step("post_rst_gnt");
        chk("post_rst_gnt_dir", 32'(gnt), 32'h2);
        step("post_rst_commit");
        chk("post_rst_q", 32'(q), 32'h1);
`ifdef DFF_ARB_LOCK_EN
        do_reset();
        req = 4'b0011; req_lock = 4'b0001; req_data = '0;
        step("lock_gnt");
        for (int k = 1; k <= 5; k++) begin
            req_data[3:0] = 4'(k);
            step("lock");
            if (k <= 4) chk("lock_q", 32'(q), 32'(k));
        end
        chk("lock_next_gnt", 32'(gnt), 32'h2);
        req_lock = '0;
`endif
        for (int i = 0; i < 400; i++) begin
            req = N'($urandom);
            req_data = (N*W)'($urandom);
            req_lock = N'($urandom);
            step("rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
